// File: rtl/aespim_pkg.sv
// Shared types and default widths for the carry-less (GF(2)) polynomial divider.
package aespim_pkg;

  localparam int GDIV_DW = 64;
  localparam int GDIV_RW = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } gdiv_state_e;

endpackage

// File: rtl/aespim_msb_idx.sv
// Combinational priority encoder: index of the highest set bit plus a nonzero flag.
module aespim_msb_idx
  import aespim_pkg::*;
#(
  parameter int W  = GDIV_RW,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          nonzero_o
);

  // Later (higher) bits overwrite earlier ones, so the last hit is the MSB.
  always_comb begin
    idx_o     = '0;
    nonzero_o = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (vec_i[k]) begin
        idx_o     = IW'(k);
        nonzero_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aespim_gdiv.sv
// Bit-serial GF(2) polynomial divider: P = clmul(Q,B) xor R, one dividend bit per CALC cycle.
module aespim_gdiv
  import aespim_pkg::*;
#(
  parameter int DW = GDIV_DW,
  parameter int RW = GDIV_RW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] dividend_i,
  input  logic [RW-1:0] divisor_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] quotient_o,
  output logic [RW-1:0] remainder_o,
  output logic          div_zero_o
);

  localparam int CW = $clog2(DW);
  localparam int IW = $clog2(RW);

  gdiv_state_e   state_q, state_d;
  logic [DW-1:0] p_q, p_d;
  logic [RW-1:0] b_q, b_d;
  logic [IW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic [RW-1:0] r_q, r_d;
  logic          dz_q, dz_d;
  logic [RW:0]   t;

  logic [IW-1:0] b_idx;
  logic          b_nz;

  aespim_msb_idx #(
    .W  (RW),
    .IW (IW)
  ) u_msb_idx (
    .vec_i     (divisor_i),
    .idx_o     (b_idx),
    .nonzero_o (b_nz)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    b_d     = b_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    // r always stays below x^d, so the shifted-in word t never needs more than RW+1 bits.
    t       = {r_q, p_q[cnt_q]};

    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          p_d   = dividend_i;
          b_d   = divisor_i;
          d_d   = b_idx;
          cnt_d = CW'(DW - 1);
          q_d   = '0;
          if (b_nz) begin
            r_d     = '0;
            dz_d    = 1'b0;
            state_d = CALC;
          end else begin
            r_d     = dividend_i[RW-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        if (t[{1'b0, d_q}]) begin
          q_d[cnt_q] = 1'b1;
          r_d        = t[RW-1:0] ^ b_q;
        end else begin
          r_d = t[RW-1:0];
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      p_q     <= '0;
      b_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      b_q     <= b_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign quotient_o  = q_q;
  assign remainder_o = r_q;
  assign div_zero_o  = dz_q;

endmodule

// File: doc/aespim_gdiv.md
AESPIM_GDIV -- requirements
Module: aespim_gdiv

Interface
REQ-001 SHALL have parameter DW, default 64, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter RW, default 32, meaning divisor and remainder width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  operand request.
REQ-006 SHALL have port in_ready_o  output  1  unit can accept operands.
REQ-007 SHALL have port dividend_i  input  DW  carry-less dividend polynomial P; bit k is the x^k coefficient.
REQ-008 SHALL have port divisor_i  input  RW  carry-less divisor polynomial B.
REQ-009 SHALL have port out_valid_o  output  1  result available.
REQ-010 SHALL have port out_ready_i  input  1  consumer takes result.
REQ-011 SHALL have port quotient_o  output  DW  Q, where P = clmul(Q,B) xor R over GF(2).
REQ-012 SHALL have port remainder_o  output  RW  R, with deg R < deg B.
REQ-013 SHALL have port div_zero_o  output  1  set with the result when B == 0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready_o high exactly in IDLE.
REQ-016 SHALL drive out_valid_o high exactly in DONE.
REQ-017 On in_valid_i && in_ready_o, SHALL register P and B, compute d = index of the MSB of B, clear the 33-bit partial remainder and Q, and load bit counter to DW-1.
REQ-018 Accept with B != 0 SHALL transition IDLE->CALC.
REQ-019 Accept with B == 0 SHALL transition IDLE->DONE with Q=0, R=P[RW-1:0], div_zero_o=1.
REQ-020 Each CALC cycle SHALL process bit i = counter, MSB first: t = {r[31:0], P[i]}; if t[d], then Q[i]=1 and r = t xor B; else r = t.
REQ-021 CALC SHALL last exactly DW cycles: counter == 0 transitions to DONE; the counter SHALL NOT wrap.
REQ-022 Latency SHALL be fixed: out_valid_o rises DW+1 cycles after the accept edge for B != 0, and 1 cycle after it for B == 0.
REQ-023 In DONE, quotient_o, remainder_o and div_zero_o SHALL hold stable until out_valid_o && out_ready_i, then transition DONE->IDLE.
REQ-024 The unit SHALL ignore in_valid_i outside IDLE; in DONE, accept and handoff SHALL NOT occur in the same cycle.
REQ-025 Outputs SHALL be registered; dividend_i and divisor_i SHALL be sampled only at the accept edge.

Reset
REQ-026 Asserting rst_i, including mid-CALC or in DONE, SHALL immediately force IDLE, counter 0, Q=0, r=0, and div_zero_o=0.
REQ-027 Under reset, in_ready_o SHALL be 1, out_valid_o SHALL be 0, and quotient_o and remainder_o SHALL be 0; any pending result SHALL be discarded.

Structure
REQ-028 Package aespim_pkg SHALL hold the FSM enum gdiv_state_e and the constants GDIV_DW=64 and GDIV_RW=32.
REQ-029 A sub-module aespim_msb_idx SHALL provide a combinational priority encoder (32-bit in; 5-bit index plus nonzero flag), used for d and for B == 0 detection.
REQ-030 The implementation SHALL be 120-400 lines total, with no multi-bit combinational division.

Verification
REQ-031 Scenario: P=0x5, B=0x3 -> Q=0x3, R=0x0, div_zero_o=0, out_valid_o at accept+65.
REQ-032 Scenario: P=0x1234, B=0x100 -> Q=0x12, R=0x34.
REQ-033 Scenario: P=0xDEADBEEF_CAFEF00D, B=0x1 -> Q=P, R=0; and with B=0 -> Q=0, R=0xCAFEF00D, div_zero_o=1, out_valid_o at accept+1.
REQ-034 Scenario: 1000 random round-trips with P=clmul(A,B) xor R, deg R < deg B -> Q=A and R returned exactly.
REQ-035 Scenario: out_ready_i held low 10 cycles in DONE -> outputs stable, in_ready_o=0, and a new in_valid_i is ignored; release -> IDLE next cycle.
REQ-036 Scenario: rst_i pulsed at CALC cycle 30 -> IDLE with outputs zero; a following P=0x5, B=0x3 -> correct result.
